// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer.
//   - One-hot shift_mag step codes. Bit 0 of the [0:4] vector is the
//     leftmost character: 10000 = right 2, 00001 = left 2.
//   - state_t: sequencer FSM states.
//   - step_code(): maps a signed step in -2..+2 to its one-hot code.
package shift_seq_pkg;

  localparam logic [0:4] SHMAG_R2   = 5'b10000;
  localparam logic [0:4] SHMAG_R1   = 5'b01000;
  localparam logic [0:4] SHMAG_NONE = 5'b00100;
  localparam logic [0:4] SHMAG_L1   = 5'b00010;
  localparam logic [0:4] SHMAG_L2   = 5'b00001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Steps outside -2..+2 cannot occur after clamping; they map to NONE so
  // the output stays one-hot regardless.
  function automatic logic [0:4] step_code(input logic signed [2:0] step);
    logic [0:4] code;
    case (step)
      -3'sd2:  code = SHMAG_R2;
      -3'sd1:  code = SHMAG_R1;
      3'sd1:   code = SHMAG_L1;
      3'sd2:   code = SHMAG_L2;
      default: code = SHMAG_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-hot shift stage, moves a word by at most 2 positions.
// Ordering is big-endian [0:WIDTH-1]; "left" moves bits toward index 0.
// Optional feature (macro SHIFT_SEQ_ROTATE_EN): input rot selects rotation
// instead of zero-fill.
// Ports:
//   data      in   [0:WIDTH-1]  word to shift
//   shift_mag in   [0:4]        one-hot step code
//   rot       in   1            rotate instead of zero-fill (macro only)
//   shifted   out  [0:WIDTH-1]  shifted word
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [0:WIDTH-1] data,
  input  logic [0:4]       shift_mag,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  output logic [0:WIDTH-1] shifted
);

  logic rot_i;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign rot_i = rot;
`else
  assign rot_i = 1'b0;
`endif

  // Fill bits: the bits that fall off the opposite end when rotating, else 0.
  logic [0:1] fill_l;
  logic [0:1] fill_r;

  assign fill_l = rot_i ? data[0:1] : 2'b00;
  assign fill_r = rot_i ? data[WIDTH-2:WIDTH-1] : 2'b00;

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned; that is what keeps a latch from being inferred.
  always_comb begin
    shifted = data;
    case (shift_mag)
      SHMAG_L1: shifted = {data[1:WIDTH-1], fill_l[0]};
      SHMAG_L2: shifted = {data[2:WIDTH-1], fill_l};
      SHMAG_R1: shifted = {fill_r[1], data[0:WIDTH-2]};
      SHMAG_R2: shifted = {fill_r, data[0:WIDTH-3]};
      default:  shifted = data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequential driver for the one-hot shift stage. Accepts a word and a signed
// shift amount, applies it in steps of at most 2 positions (one per cycle,
// fed back through data_r) and returns the result over a second handshake.
// Optional feature (macro SHIFT_SEQ_ROTATE_EN): adds req_rot to select
// rotation for the whole transfer.
// Ports:
//   clk        in   1            clock, all state on rising edge
//   rst        in   1            synchronous active-high reset
//   req_valid  in   1            request present
//   req_ready  out  1            high only in IDLE
//   req_data   in   [0:WIDTH-1]  word to shift
//   req_amt    in   [AMT_W-1:0]  signed amount, + = left, - = right
//   req_rot    in   1            rotate request (macro only)
//   rsp_valid  out  1            result available
//   rsp_ready  in   1            consumer accepts result
//   rsp_data   out  [0:WIDTH-1]  shifted word
//   shift_mag  out  [0:4]        one-hot step code currently applied
//   busy       out  1            high in SHIFT or DONE
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [0:WIDTH-1]        req_data,
  input  logic signed [AMT_W-1:0] req_amt,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic                    req_rot,
`endif
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [0:WIDTH-1]        rsp_data,
  output logic [0:4]              shift_mag,
  output logic                    busy
);

  // One extra bit so the most negative amount can be stepped toward zero.
  localparam int RW = AMT_W + 1;
  localparam logic signed [RW-1:0] POS2 = RW'(2);
  localparam logic signed [RW-1:0] NEG2 = -RW'(2);

  state_t                 state_q, state_d;
  logic [0:WIDTH-1]       data_r, data_d;
  logic signed [RW-1:0]   rem_r, rem_d;
  logic signed [2:0]      step;
  logic [0:WIDTH-1]       stage_out;
  logic                   rot_r;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_d;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data      (data_r),
    .shift_mag (shift_mag),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rot       (rot_r),
`endif
    .shifted   (stage_out)
  );

  always_comb begin
    if (rem_r > POS2)
      step = 3'sd2;
    else if (rem_r < NEG2)
      step = -3'sd2;
    else
      step = rem_r[2:0];
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_r;
    rem_d     = rem_r;
    shift_mag = SHMAG_NONE;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_d     = rot_r;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          data_d  = req_data;
          rem_d   = RW'(req_amt);
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_d   = req_rot;
`endif
          state_d = (req_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        shift_mag = step_code(step);
        data_d    = stage_out;
        rem_d     = rem_r - RW'(step);
        if (rem_d == '0)
          state_d = DONE;
      end
      DONE: begin
        // New requests wait for IDLE; no same-cycle re-accept.
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_r  <= '0;
      rem_r   <= '0;
      rot_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_r  <= data_d;
      rem_r   <= rem_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_r   <= rot_d;
`else
      rot_r   <= 1'b0;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = data_r;

`ifndef SYNTHESIS
  a_mag_onehot: assert property (@(posedge clk) $onehot(shift_mag));
  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> $stable(rsp_data));
  a_rem_nonzero: assert property (@(posedge clk) disable iff (rst)
    (state_q == SHIFT) |-> (rem_r != '0));
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (WIDTH=8, AMT_W=4).
// Define SHIFT_SEQ_ROTATE_EN to include the rotate scenario.
module tb_shift_sequencer;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [0:7]        req_data;
  logic signed [3:0] req_amt;
  logic              req_rot;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:7]        rsp_data;
  logic [0:4]        shift_mag;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
`ifdef SHIFT_SEQ_ROTATE_EN
    .req_rot   (req_rot),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .shift_mag (shift_mag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations of one transfer, compared by the calling test.
  logic [0:4] obs_codes [16];
  int         obs_n;
  int         obs_edges;
  logic [0:7] obs_data;
  logic       obs_timeout;

  // Drives one request, then records the shift_mag code of every SHIFT cycle
  // and the number of edges (accept edge counted as 1) until rsp_valid.
  task automatic run_shift(input logic [0:7] d, input logic signed [3:0] a,
                           input logic r);
    @(negedge clk);
    req_data  = d;
    req_amt   = a;
    req_rot   = r;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    obs_edges = 1;
    obs_n     = 0;
    while (!rsp_valid && obs_edges < 20) begin
      if (obs_n < 16) obs_codes[obs_n] = shift_mag;
      obs_n++;
      @(posedge clk);
      #1;
      obs_edges++;
    end
    obs_timeout = !rsp_valid;
    obs_data    = rsp_data;
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({req_ready, rsp_valid, busy, shift_mag, rsp_data} !== {1'b1, 1'b0, 1'b0, 5'b00100, 8'h00}) begin
      n_fail++;
      $display("FAIL por_state: got rdy=%b vld=%b busy=%b mag=%b data=%b expected 1 0 0 00100 00000000",
               req_ready, rsp_valid, busy, shift_mag, rsp_data);
    end
    // Start amt=+6 and reset it mid-SHIFT.
    @(negedge clk);
    req_data = 8'hFF; req_amt = 4'sd6; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_busy: got %b expected 1", busy);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({req_ready, rsp_valid, busy, shift_mag, rsp_data} !== {1'b1, 1'b0, 1'b0, 5'b00100, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_reset_state: got rdy=%b vld=%b busy=%b mag=%b data=%b expected 1 0 0 00100 00000000",
               req_ready, rsp_valid, busy, shift_mag, rsp_data);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_no_rsp: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_left1();
    run_shift(8'b0000_0001, 4'sd1, 1'b0);
    n_checks++;
    if (obs_timeout || obs_n !== 1 || obs_codes[0] !== 5'b00010) begin
      n_fail++;
      $display("FAIL left1_codes: got n=%0d c0=%b to=%b expected n=1 c0=00010", obs_n, obs_codes[0], obs_timeout);
    end
    n_checks++;
    if (obs_data !== 8'b0000_0010 || obs_edges !== 2) begin
      n_fail++;
      $display("FAIL left1_result: got %b after %0d edges expected 00000010 after 2", obs_data, obs_edges);
    end
    n_checks++;
    if (shift_mag !== 5'b00100 || req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_outputs: got mag=%b rdy=%b busy=%b expected 00100 0 1", shift_mag, req_ready, busy);
    end
    finish_rsp();
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL left1_release: got rdy=%b vld=%b expected 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_right2();
    run_shift(8'b1010_1101, -4'sd2, 1'b0);
    n_checks++;
    if (obs_timeout || obs_n !== 1 || obs_codes[0] !== 5'b10000) begin
      n_fail++;
      $display("FAIL right2_codes: got n=%0d c0=%b to=%b expected n=1 c0=10000", obs_n, obs_codes[0], obs_timeout);
    end
    n_checks++;
    if (obs_data !== 8'b0010_1011 || obs_edges !== 2) begin
      n_fail++;
      $display("FAIL right2_result: got %b after %0d edges expected 00101011 after 2", obs_data, obs_edges);
    end
    finish_rsp();
  endtask

  task automatic test_left5();
    run_shift(8'b1010_1101, 4'sd5, 1'b0);
    n_checks++;
    if (obs_timeout || obs_n !== 3 || obs_codes[0] !== 5'b00001 ||
        obs_codes[1] !== 5'b00001 || obs_codes[2] !== 5'b00010) begin
      n_fail++;
      $display("FAIL left5_codes: got n=%0d %b %b %b expected 3 00001 00001 00010",
               obs_n, obs_codes[0], obs_codes[1], obs_codes[2]);
    end
    n_checks++;
    if (obs_data !== 8'b1010_0000 || obs_edges !== 4) begin
      n_fail++;
      $display("FAIL left5_result: got %b after %0d edges expected 10100000 after 4", obs_data, obs_edges);
    end
    finish_rsp();
  endtask

  task automatic test_zero();
    run_shift(8'b1010_1101, 4'sd0, 1'b0);
    n_checks++;
    if (obs_timeout || obs_n !== 0 || shift_mag !== 5'b00100) begin
      n_fail++;
      $display("FAIL zero_codes: got n=%0d mag=%b expected 0 shift cycles mag=00100", obs_n, shift_mag);
    end
    n_checks++;
    if (obs_data !== 8'b1010_1101 || obs_edges !== 1) begin
      n_fail++;
      $display("FAIL zero_result: got %b after %0d edges expected 10101101 after 1", obs_data, obs_edges);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int bad;
    run_shift(8'b1111_1111, -4'sd8, 1'b0);
    bad = 0;
    for (int i = 0; i < 4; i++) if (obs_codes[i] !== 5'b10000) bad++;
    n_checks++;
    if (obs_timeout || obs_n !== 4 || bad !== 0) begin
      n_fail++;
      $display("FAIL maxr_codes: got n=%0d bad=%0d expected four 10000 steps", obs_n, bad);
    end
    n_checks++;
    if (obs_data !== 8'h00 || obs_edges !== 5) begin
      n_fail++;
      $display("FAIL maxr_result: got %b after %0d edges expected 00000000 after 5", obs_data, obs_edges);
    end
    // Backpressure for 3 cycles with a request pulse that must be ignored.
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = (i == 1);
      req_data  = 8'b1000_0001;
      req_amt   = 4'sd0;
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || req_ready !== 1'b0) bad++;
    end
    req_valid = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL maxr_hold: got %0d bad cycles expected 0", bad);
    end
    finish_rsp();
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL maxr_ignored_req: got rdy=%b busy=%b expected 1 0", req_ready, busy);
    end
    // Immediately follow with another request.
    run_shift(8'b0000_0011, 4'sd2, 1'b0);
    n_checks++;
    if (obs_timeout || obs_data !== 8'b0000_1100 || obs_edges !== 2) begin
      n_fail++;
      $display("FAIL b2b_result: got %b after %0d edges expected 00001100 after 2", obs_data, obs_edges);
    end
    finish_rsp();
  endtask

`ifdef SHIFT_SEQ_ROTATE_EN
  task automatic test_rotate();
    run_shift(8'b1010_1101, 4'sd3, 1'b1);
    n_checks++;
    if (obs_timeout || obs_data !== 8'b0110_1101 || obs_edges !== 3) begin
      n_fail++;
      $display("FAIL rotate_result: got %b after %0d edges expected 01101101 after 3", obs_data, obs_edges);
    end
    finish_rsp();
    run_shift(8'b1010_1101, -4'sd3, 1'b1);
    n_checks++;
    if (obs_timeout || obs_data !== 8'b1011_0101) begin
      n_fail++;
      $display("FAIL rotate_right: got %b expected 10110101", obs_data);
    end
    finish_rsp();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    req_amt   = '0;
    req_rot   = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_left1();
    test_right2();
    test_left5();
    test_zero();
    test_back_to_back();
`ifdef SHIFT_SEQ_ROTATE_EN
    test_rotate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
